imem_port_arbiter: RTL and testbench

//  Shares the single combinational read port of the instruction memory between
//  the CPU fetch stage and the debug/monitor read port. Grants at most one

---
 rtl/imem_port_arbiter.sv | 109 ++++++++++
 tb/tb_imem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the instruction memory read port: fetch normally wins,
// but a debug request denied STARVE_LIMIT cycles in a row is forced through.
module imem_port_arbiter #(
    parameter int unsigned AW           = 11,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LimitVal = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StIf   = 2'b01,
        StDbg  = 2'b10
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          force_dbg;

    assign force_dbg = (starve_q == LimitVal);

    // Grants are suppressed during reset so no read is launched in that cycle.
    always_comb begin
        if_gnt   = 1'b0;
        dbg_gnt  = 1'b0;
        mem_addr = if_addr;
        if (!rst) begin
            if (dbg_req && (force_dbg || !if_req)) begin
                dbg_gnt  = 1'b1;
                mem_addr = dbg_addr;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d     = '0;
        owner_d      = StIdle;
        if_rvalid_d  = if_gnt;
        dbg_rvalid_d = dbg_gnt;
        if_rdata_d   = if_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        if (dbg_req && !dbg_gnt) begin
            starve_d = force_dbg ? starve_q : starve_q + CW'(1);
        end

        if (dbg_gnt) begin
            owner_d = StDbg;
        end else if (if_gnt) begin
            owner_d = StIf;
        end

        if (if_gnt) begin
            if_rdata_d = mem_rdata;
        end
        if (dbg_gnt) begin
            dbg_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= StIdle;
            starve_q     <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            if_rvalid_q  <= if_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the arbitration and read-data rules.
module tb_imem_port_arbiter;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int          LIMIT = 4;

    logic          clk;
    logic          rst;
    logic          if_req, dbg_req;
    logic [AW-1:0] if_addr, dbg_addr;
    logic          if_gnt, if_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] if_rdata, dbg_rdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;

    logic [DW-1:0] imem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int            m_starve;
    int            m_owner;
    logic          m_if_rv, m_dbg_rv;
    logic [DW-1:0] m_if_rd, m_dbg_rd;
    bit            m_init = 0;

    // Per-step samples taken from the DUT for directed literal checks
    logic          s_if_gnt, s_dbg_gnt, s_if_rv, s_dbg_rv;
    logic [DW-1:0] s_if_rd, s_dbg_rd;
    logic [1:0]    s_owner;

    int n_if_gnt = 0, n_dbg_gnt = 0, n_if_rv = 0, n_dbg_rv = 0;

    imem_port_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    assign mem_rdata = imem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input logic r, input logic ireq, input logic [AW-1:0] ia,
                        input logic dreq, input logic [AW-1:0] da);
        logic e_if, e_dbg;
        @(negedge clk);
        rst      = r;
        if_req   = ireq;
        if_addr  = ia;
        dbg_req  = dreq;
        dbg_addr = da;
        #1;
        e_dbg = !r && dreq && ((m_starve >= LIMIT) || !ireq);
        e_if  = !r && ireq && !e_dbg;
        chk("dbg_gnt", dbg_gnt, e_dbg);
        chk("if_gnt", if_gnt, e_if);
        chk("gnt_onehot", if_gnt & dbg_gnt, 0);
        if (e_dbg) chk("mem_addr_dbg", mem_addr, da);
        else if (!r) chk("mem_addr_if", mem_addr, ia);
        if (m_init) begin
            chk("if_rvalid", if_rvalid, m_if_rv);
            chk("dbg_rvalid", dbg_rvalid, m_dbg_rv);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dbg_rdata", dbg_rdata, m_dbg_rd);
            chk("owner", owner, m_owner[1:0]);
            n_if_rv  += int'(if_rvalid);
            n_dbg_rv += int'(dbg_rvalid);
        end
        n_if_gnt  += int'(if_gnt === 1'b1);
        n_dbg_gnt += int'(dbg_gnt === 1'b1);
        s_if_gnt = if_gnt;   s_dbg_gnt = dbg_gnt;
        s_if_rv  = if_rvalid; s_dbg_rv = dbg_rvalid;
        s_if_rd  = if_rdata;  s_dbg_rd = dbg_rdata;
        s_owner  = owner;
        @(posedge clk);
        if (r) begin
            m_starve = 0; m_owner = 0;
            m_if_rv = 0; m_dbg_rv = 0; m_if_rd = '0; m_dbg_rd = '0;
            m_init = 1;
        end else begin
            m_starve = (dreq && !e_dbg) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
            m_if_rv  = e_if;
            m_dbg_rv = e_dbg;
            if (e_if) m_if_rd = imem[ia];
            if (e_dbg) m_dbg_rd = imem[da];
            m_owner = e_dbg ? 2 : (e_if ? 1 : 0);
        end
    endtask

    initial begin
        logic          ir, dr;
        logic [AW-1:0] ia, da;
        int            first;

        rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;
        m_starve = 0; m_owner = 0; m_if_rv = 0; m_dbg_rv = 0; m_if_rd = '0; m_dbg_rd = '0;
        for (int i = 0; i < (1 << AW); i++) imem[i] = $urandom;
        for (int i = 0; i < 4; i++) imem[i] = 32'h2008_0000 + i;
        imem[11'h7FF] = 32'hDEAD_BEEF;

        // 1: reset with both requesting
        step(1, 1, 11'h010, 1, 11'h020);
        step(1, 1, 11'h010, 1, 11'h020);
        chk("s1_if_gnt", s_if_gnt, 0);
        chk("s1_dbg_gnt", s_dbg_gnt, 0);
        chk("s1_if_rvalid", s_if_rv, 0);
        chk("s1_if_rdata", s_if_rd, 0);
        chk("s1_owner", s_owner, 0);

        // 2: streaming fetch
        for (int k = 0; k < 4; k++) begin
            step(0, 1, AW'(k), 0, '0);
            chk("s2_if_gnt", s_if_gnt, 1);
            if (k > 0) begin
                chk("s2_if_rvalid", s_if_rv, 1);
                chk("s2_if_rdata", s_if_rd, 32'h2008_0000 + k - 1);
            end
        end
        step(0, 0, '0, 0, '0);
        chk("s2_last_rdata", s_if_rd, 32'h2008_0003);
        chk("s2_last_rvalid", s_if_rv, 1);

        // 3: debug read of top word
        step(0, 0, '0, 1, 11'h7FF);
        chk("s3_dbg_gnt", s_dbg_gnt, 1);
        step(0, 0, '0, 0, '0);
        chk("s3_dbg_rvalid", s_dbg_rv, 1);
        chk("s3_dbg_rdata", s_dbg_rd, 32'hDEAD_BEEF);
        chk("s3_if_rvalid", s_if_rv, 0);
        chk("s3_owner", s_owner, 2'b10);

        // 4: continuous fetch, debug forced through after four denials
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 11'h100, 1, 11'h200);
            chk("s4_if_gnt", s_if_gnt, (c != 4));
            chk("s4_dbg_gnt", s_dbg_gnt, (c == 4));
        end

        // 5: reset lands on the forced-debug cycle
        step(1, 0, '0, 0, '0);
        for (int c = 0; c < 4; c++) step(0, 1, 11'h300, 1, 11'h301);
        step(1, 1, 11'h300, 1, 11'h301);
        chk("s5_rst_dbg_gnt", s_dbg_gnt, 0);
        step(0, 1, 11'h300, 1, 11'h301);
        chk("s5_dbg_rvalid", s_dbg_rv, 0);
        chk("s5_if_rvalid", s_if_rv, 0);
        chk("s5_if_first", s_if_gnt, 1);

        // 6: debug drops after two denials; its starvation count restarts
        step(1, 0, '0, 0, '0);
        step(0, 1, 11'h050, 1, 11'h060);
        step(0, 1, 11'h050, 1, 11'h060);
        step(0, 1, 11'h050, 0, 11'h060);
        first = -1;
        for (int c = 0; c < 10; c++) begin
            step(0, 1, 11'h050, 1, 11'h061);
            if (first < 0 && s_dbg_gnt === 1'b1) first = c;
        end
        chk("s6_dbg_wait", 64'(first), 64'(4));

        // Randomized traffic obeying the hold-until-grant rule
        ir = 0; dr = 0; ia = '0; da = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!ir || s_if_gnt === 1'b1 || ($urandom % 16) == 0) begin
                ir = ($urandom % 4) != 0;
                ia = AW'($urandom);
            end
            if (!dr || s_dbg_gnt === 1'b1 || ($urandom % 16) == 0) begin
                dr = ($urandom % 3) == 0;
                da = AW'($urandom);
            end
            step(($urandom % 200) == 0, ir, ia, dr, da);
        end
        step(0, 0, '0, 0, '0);

        chk("if_rvalid_per_gnt", 64'(n_if_rv), 64'(n_if_gnt));
        chk("dbg_rvalid_per_gnt", 64'(n_dbg_rv), 64'(n_dbg_gnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
